pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Sequencer for the 4-bit magnitude comparator in the fan/PWM path; the comparator output is (in > ref).
//  Generates the free-running sawtooth count that feeds the comparator 'in' input.
//  Drives the comparator 'ref' input, and accepts new duty targets over a valid/ready handshake.
//  Slews 'ref' toward each target one step per PWM period (soft ramp).
//  'ref' changes only on period boundaries, so a PWM period is never truncated.
// PARAMETERS
//  CNT_W      4   width of count, ref and target (matches the 4-bit comparator)
//  PRESC      4   clk cycles per count tick; legal range >= 1 (1 = tick every clk)
//  RAMP_STEP  1   max |ref change| per period; legal range 1..2^CNT_W-1
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  en           in   1      run enable, sampled synchronously
//  duty_tgt     in   CNT_W  requested ref target
//  duty_valid   in   1      duty_tgt is valid
//  duty_ready   out  1      controller can accept a target this cycle
//  cnt_out      out  CNT_W  sawtooth count; drives the comparator 'in'
//  ref_out      out  CNT_W  current ref; drives the comparator 'ref'
//  period_end   out  1      1-clk pulse on the tick where cnt_out wraps from max to 0
//  busy         out  1      1 while state == RAMP
// BEHAVIOUR
//  Reset: all outputs, the target register and the prescaler are 0. State = IDLE.
//  All outputs are registered.
//  Prescaler:
//   - Counts 0..PRESC-1 only while state != IDLE.
//   - tick = (presc == PRESC-1); presc then wraps to 0.
//  Counter:
//   - On tick, cnt_out increments modulo 2^CNT_W.
//   - period_end = 1 for the clk cycle in which cnt_out becomes 0 by wrapping.
//  Handshake:
//   - A transfer occurs when duty_valid & duty_ready at a rising clk edge; duty_tgt is latched into tgt.
//   - duty_ready = 1 in IDLE and HOLD, 0 in RAMP.
//   - duty_valid can be held high indefinitely without side effects.
//   - Once in HOLD, the same value is re-accepted every cycle; this is harmless.
//  FSM:
//   IDLE
//    - cnt_out, presc and ref_out are held at 0.
//    - A transfer still latches tgt.
//    - en=1 -> RAMP if tgt != 0, else HOLD.
//   RAMP
//    - On each period_end, ref_out moves toward tgt by min(RAMP_STEP, |tgt-ref_out|).
//    - Arithmetic is unsigned. ref_out never overshoots tgt and never wraps.
//    - Go to HOLD in the same cycle that ref_out reaches tgt.
//   HOLD
//    - ref_out is constant.
//    - A transfer with duty_tgt != ref_out -> RAMP on the next cycle.
//    - A transfer with duty_tgt == ref_out stays in HOLD.
//  en=0 in any state:
//   - Next cycle: state = IDLE; cnt_out, presc and ref_out are cleared.
//   - tgt is retained.
//   - A transfer in the same cycle is still accepted, and tgt takes the new value.
//  Simultaneous events:
//   - A transfer in HOLD coincident with period_end: tgt updates, ref_out does not move on that edge.
//     The ramp begins at the next period_end.
//  Latency: a target accepted in HOLD first moves ref_out at the first period_end after entering RAMP.
//  Reset mid-operation: asynchronous return to the reset values; any ramp in progress is abandoned.
// TESTING
//  1. Reset asserted mid-RAMP -> all outputs 0 and state IDLE immediately, with no clk edge needed.
//  2. PRESC=4, en=1, tgt=0:
//     - cnt_out steps every 4 clk.
//     - Wrap 15 -> 0 occurs every 64 clk.
//     - period_end is a single-cycle pulse each time.
//  3. HOLD at ref=0, then send duty_tgt=5 with RAMP_STEP=2:
//     - ref_out goes 2, 4, 5 on successive period_ends.
//     - busy=1 and duty_ready=0 until ref_out=5, then HOLD.
//  4. From HOLD at ref=12, send duty_tgt=3 with RAMP_STEP=4:
//     - ref_out goes 8, 4, 3 (decreasing, no underflow).
//     - duty_valid held high during RAMP is not accepted.
//  5. en dropped mid-RAMP (ref=6, tgt=10):
//     - Next cycle: IDLE, cnt_out=0, ref_out=0.
//     - On re-enable, ramps 0 -> 10.
//  6. Transfer coincident with period_end in HOLD:
//     - ref_out is unchanged on that edge.
//     - The first step occurs at the following period_end.

Source files
------------

// File: rtl/pwm_ramp_ctrl_if.sv
// Handshake and output bundle between a duty-target source and pwm_ramp_ctrl.
// The master side supplies enable and duty targets; the slave (the controller)
// returns the ready flag, the sawtooth count, the comparator ref and status.
interface pwm_ramp_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             en;
  logic [CNT_W-1:0] duty_tgt;
  logic             duty_valid;
  logic             duty_ready;
  logic [CNT_W-1:0] cnt_out;
  logic [CNT_W-1:0] ref_out;
  logic             period_end;
  logic             busy;

  modport master (
    output en, duty_tgt, duty_valid,
    input  duty_ready, cnt_out, ref_out, period_end, busy
  );

  modport slave (
    input  en, duty_tgt, duty_valid,
    output duty_ready, cnt_out, ref_out, period_end, busy
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM ramp sequencer for a 4-bit magnitude comparator (out = in > ref).
// Produces the free-running sawtooth that feeds the comparator 'in', and the
// 'ref' level, which slews toward the latest accepted duty target by at most
// RAMP_STEP per PWM period. 'ref' only moves on the wrap of the sawtooth, so
// no PWM period is ever cut short. Every output comes straight from a flop.
module pwm_ramp_ctrl #(
  parameter int CNT_W     = 4,
  parameter int PRESC     = 4,
  parameter int RAMP_STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  pwm_ramp_ctrl_if.slave bus
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STEP      = CNT_W'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] ref_reg, ref_next;
  logic [CNT_W-1:0] tgt_reg, tgt_next;
  logic             period_end_reg, period_end_next;
  logic             busy_reg;
  logic             duty_ready_reg;

  logic             active;
  logic             tick;
  logic             wrap;
  logic             xfer;
  logic             ramp_up;
  logic [CNT_W-1:0] diff;
  logic [CNT_W-1:0] step_amt;
  logic [CNT_W-1:0] ref_stepped;

  // The prescaler and counter only run outside IDLE; a wrap is the tick on
  // which the counter rolls over from its maximum back to zero.
  assign active = (state_reg != IDLE);
  assign tick   = active && (presc_reg == PRESC_MAX);
  assign wrap   = tick && (cnt_reg == CNT_MAX);
  assign xfer   = bus.duty_valid && duty_ready_reg;

  // Clamp the step to the remaining distance so ref lands exactly on the
  // target without overshoot or unsigned wrap in either direction.
  assign ramp_up     = (tgt_reg >= ref_reg);
  assign diff        = ramp_up ? (tgt_reg - ref_reg) : (ref_reg - tgt_reg);
  assign step_amt    = (diff < STEP) ? diff : STEP;
  assign ref_stepped = ramp_up ? (ref_reg + step_amt) : (ref_reg - step_amt);

  // Next-state, timing and ramp logic.
  always_comb begin
    state_next      = state_reg;
    presc_next      = presc_reg;
    cnt_next        = cnt_reg;
    ref_next        = ref_reg;
    tgt_next        = tgt_reg;
    period_end_next = 1'b0;

    // A handshake always lands in tgt, even while disabled or idle.
    if (xfer) begin
      tgt_next = bus.duty_tgt;
    end

    if (!bus.en) begin
      state_next = IDLE;
      presc_next = '0;
      cnt_next   = '0;
      ref_next   = '0;
    end else begin
      if (active) begin
        presc_next      = tick ? '0 : presc_reg + 1'b1;
        period_end_next = wrap;
        if (tick) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      unique case (state_reg)
        IDLE: begin
          state_next = (tgt_reg != '0) ? RAMP : HOLD;
        end
        RAMP: begin
          if (wrap) begin
            ref_next = ref_stepped;
            if (ref_stepped == tgt_reg) begin
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          // A new target taken on a wrap edge leaves ref alone on that edge;
          // the first step happens on the following wrap.
          if (xfer && (bus.duty_tgt != ref_reg)) begin
            state_next = RAMP;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      presc_reg      <= '0;
      cnt_reg        <= '0;
      ref_reg        <= '0;
      tgt_reg        <= '0;
      period_end_reg <= 1'b0;
      busy_reg       <= 1'b0;
      duty_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= presc_next;
      cnt_reg        <= cnt_next;
      ref_reg        <= ref_next;
      tgt_reg        <= tgt_next;
      period_end_reg <= period_end_next;
      busy_reg       <= (state_next == RAMP);
      duty_ready_reg <= (state_next != RAMP);
    end
  end

  assign bus.duty_ready = duty_ready_reg;
  assign bus.cnt_out    = cnt_reg;
  assign bus.ref_out    = ref_reg;
  assign bus.period_end = period_end_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl. Two instances share clk/rst: dut_a ramps
// by 2 per period and dut_b by 4; 'sel' routes stimulus to one of them (the
// other sees en=0) and picks which outputs are observed. Expected ref values
// are pushed into a queue when a target is sent and popped on each period_end.
module tb_pwm_ramp_ctrl;
  localparam int CNT_W = 4;
  localparam int PRESC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             sel;
  logic             en;
  logic             duty_valid;
  logic [CNT_W-1:0] duty_tgt;

  pwm_ramp_ctrl_if #(.CNT_W(CNT_W)) if_a ();
  pwm_ramp_ctrl_if #(.CNT_W(CNT_W)) if_b ();

  assign if_a.en         = en & ~sel;
  assign if_a.duty_valid = duty_valid & ~sel;
  assign if_a.duty_tgt   = duty_tgt;
  assign if_b.en         = en & sel;
  assign if_b.duty_valid = duty_valid & sel;
  assign if_b.duty_tgt   = duty_tgt;

  pwm_ramp_ctrl #(.CNT_W(CNT_W), .PRESC(PRESC), .RAMP_STEP(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  pwm_ramp_ctrl #(.CNT_W(CNT_W), .PRESC(PRESC), .RAMP_STEP(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  logic [CNT_W-1:0] cnt_o, ref_o;
  logic             pe_o, busy_o, ready_o;
  assign cnt_o   = sel ? if_b.cnt_out    : if_a.cnt_out;
  assign ref_o   = sel ? if_b.ref_out    : if_a.ref_out;
  assign pe_o    = sel ? if_b.period_end : if_a.period_end;
  assign busy_o  = sel ? if_b.busy       : if_a.busy;
  assign ready_o = sel ? if_b.duty_ready : if_a.duty_ready;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Expected ref sequence for a ramp from 'from' to 'to' with a given step.
  task automatic push_ramp(input int from, input int to, input int step_sz);
    int r;
    r = from;
    while (r != to) begin
      if (to > r) r = r + (((to - r) < step_sz) ? (to - r) : step_sz);
      else        r = r - (((r - to) < step_sz) ? (r - to) : step_sz);
      exp_q.push_back(CNT_W'(r));
    end
  endtask

  task automatic send(input logic [CNT_W-1:0] v);
    chk("ready_before_xfer", ready_o, 1);
    duty_tgt   = v;
    duty_valid = 1'b1;
    clk_step();
    duty_valid = 1'b0;
    $display("xfer dut=%s tgt=%0d", sel ? "b" : "a", v);
  endtask

  // Follow a ramp: ref may only move on period_end and must match the queue.
  task automatic run_ramp(input bit final_hold, input int bound);
    logic [CNT_W-1:0] prev;
    logic [CNT_W-1:0] e;
    int n;
    prev = ref_o;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      clk_step();
      n++;
      if (pe_o) begin
        e = exp_q.pop_front();
        chk("ramp_ref", ref_o, e);
        $display("period_end dut=%s ref=%0d expected=%0d busy=%0b", sel ? "b" : "a", ref_o, e, busy_o);
        if (exp_q.size() == 0 && final_hold) begin
          chk("hold_busy", busy_o, 0);
          chk("hold_ready", ready_o, 1);
          duty_valid = 1'b0;
        end else begin
          chk("ramp_busy", busy_o, 1);
          chk("ramp_ready", ready_o, 0);
        end
      end else begin
        chk("ref_steady", ref_o, prev);
        chk("ramp_busy_mid", busy_o, 1);
      end
      prev = ref_o;
    end
    if (exp_q.size() != 0) begin
      chk("ramp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_pe(input int bound);
    int n;
    n = 0;
    while (!pe_o && n < bound) begin
      clk_step();
      n++;
    end
    if (!pe_o) chk("pe_timeout", pe_o, 1);
  endtask

  initial begin
    int last_chg, last_pe, pulses;
    logic [CNT_W-1:0] prev_cnt;
    logic prev_pe;

    rst = 1'b1; sel = 1'b0; en = 1'b0; duty_valid = 1'b0; duty_tgt = '0;

    // Power-on reset values.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cnt", cnt_o, 0);
    chk("rst_ref", ref_o, 0);
    chk("rst_pe", pe_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 0);
    rst = 1'b0;
    clk_step();
    chk("idle_ready", ready_o, 1);
    chk("idle_cnt", cnt_o, 0);

    // Sawtooth with tgt=0: enter HOLD, count every 4 clk, wrap every 64.
    en = 1'b1;
    clk_step();
    chk("hold_entry_busy", busy_o, 0);
    chk("hold_entry_ready", ready_o, 1);
    last_chg = 0; last_pe = 0; pulses = 0; prev_cnt = cnt_o; prev_pe = 1'b0;
    for (int i = 1; i <= 140; i++) begin
      clk_step();
      if (cnt_o != prev_cnt) begin
        chk("cnt_gap", i - last_chg, PRESC);
        chk("cnt_incr", cnt_o, CNT_W'(prev_cnt + 1'b1));
        last_chg = i;
      end
      if (pe_o) begin
        pulses++;
        chk("pe_cnt_zero", cnt_o, 0);
        chk("pe_spacing", i - last_pe, 64);
        chk("pe_single", prev_pe, 0);
        $display("period_end at cycle %0d cnt=%0d", i, cnt_o);
        last_pe = i;
      end
      prev_cnt = cnt_o;
      prev_pe  = pe_o;
    end
    chk("pe_pulses", pulses, 2);

    // Ramp up 0 -> 5 with step 2.
    send(4'd5);
    chk("ramp_start_busy", busy_o, 1);
    chk("ramp_start_ready", ready_o, 0);
    push_ramp(0, 5, 2);
    run_ramp(1'b1, 300);

    // dut_b: reach HOLD at 12, then ramp down to 3 with valid held high.
    en = 1'b0;
    sel = 1'b1;
    clk_step();
    send(4'd12);
    en = 1'b1;
    clk_step();
    chk("b_ramp_busy", busy_o, 1);
    push_ramp(0, 12, 4);
    run_ramp(1'b1, 300);
    chk("b_ready_hold", ready_o, 1);
    duty_tgt = 4'd3;
    duty_valid = 1'b1;
    clk_step();
    $display("xfer dut=b tgt=3 (valid kept high)");
    chk("b_down_busy", busy_o, 1);
    chk("b_down_ready", ready_o, 0);
    duty_tgt = 4'd9;
    push_ramp(12, 3, 4);
    run_ramp(1'b1, 300);
    clk_step();
    chk("b_down_final", ref_o, 3);
    chk("b_down_idle_busy", busy_o, 0);

    // dut_a: en dropped mid-ramp at ref=6, tgt=10; then re-enable.
    en = 1'b0;
    sel = 1'b0;
    clk_step();
    send(4'd10);
    en = 1'b1;
    clk_step();
    chk("a_ramp_busy", busy_o, 1);
    push_ramp(0, 6, 2);
    run_ramp(1'b0, 250);
    chk("a_mid_ref", ref_o, 6);
    en = 1'b0;
    clk_step();
    chk("dis_cnt", cnt_o, 0);
    chk("dis_ref", ref_o, 0);
    chk("dis_busy", busy_o, 0);
    chk("dis_ready", ready_o, 1);
    chk("dis_pe", pe_o, 0);
    repeat (3) clk_step();
    chk("dis_cnt_held", cnt_o, 0);
    en = 1'b1;
    clk_step();
    chk("reen_busy", busy_o, 1);
    push_ramp(0, 10, 2);
    run_ramp(1'b1, 400);

    // Transfer on the same edge as period_end while in HOLD at 10.
    clk_step();
    wait_pe(80);
    repeat (63) clk_step();
    chk("pre_coinc_ready", ready_o, 1);
    duty_tgt = 4'd4;
    duty_valid = 1'b1;
    clk_step();
    duty_valid = 1'b0;
    $display("xfer dut=a tgt=4 (on period_end)");
    chk("coinc_pe", pe_o, 1);
    chk("coinc_ref", ref_o, 10);
    chk("coinc_busy", busy_o, 1);
    push_ramp(10, 4, 2);
    run_ramp(1'b1, 300);

    // Asynchronous reset in the middle of a ramp.
    send(4'd15);
    clk_step();
    wait_pe(80);
    chk("pre_rst_ref", ref_o, 6);
    repeat (5) clk_step();
    #3;
    rst = 1'b1;
    #1;
    chk("async_cnt", cnt_o, 0);
    chk("async_ref", ref_o, 0);
    chk("async_pe", pe_o, 0);
    chk("async_busy", busy_o, 0);
    chk("async_ready", ready_o, 0);
    repeat (2) clk_step();
    chk("rst_hold_busy", busy_o, 0);
    #2;
    rst = 1'b0;
    clk_step();
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
